// File: rtl/i2si_rx_fifo_if.sv
// Bus between the I2S receiver/consumer side and the RX sample FIFO.
interface i2si_rx_fifo_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic          i2si_push;
    logic [DW-1:0] i2si_din;
    logic          pop;
    logic          trig_i2si_fifo_overrun_clr;
    logic [DW-1:0] dout;
    logic          empty;
    logic          full;
    logic [AW:0]   level;
    logic          overrun;
    logic [7:0]    overrun_cnt;

    // Producer/consumer side: drives strobes, observes FIFO status.
    modport master (
        output i2si_push, i2si_din, pop, trig_i2si_fifo_overrun_clr,
        input  dout, empty, full, level, overrun, overrun_cnt
    );

    // FIFO side.
    modport slave (
        input  i2si_push, i2si_din, pop, trig_i2si_fifo_overrun_clr,
        output dout, empty, full, level, overrun, overrun_cnt
    );
endinterface

// File: rtl/i2si_rx_fifo.sv
// I2S receive sample FIFO: show-ahead register FIFO with a sticky overrun
// flag and a saturating dropped-sample counter.
module i2si_rx_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input logic             clk,
    input logic             rst_n,
    i2si_rx_fifo_if.slave   bus
);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          is_empty, is_full, do_push, do_pop, drop;

    // Next-state: a pop on a full FIFO frees the slot the push needs,
    // so push+pop while full is legal; a pop on empty is ignored.
    always_comb begin
        is_empty  = (level_q == '0);
        is_full   = (level_q == FULL_LVL);
        do_pop    = bus.pop && !is_empty;
        do_push   = bus.i2si_push && (!is_full || bus.pop);
        drop      = bus.i2si_push && is_full && !bus.pop;
        wr_ptr_d  = wr_ptr_q + AW'(do_push);
        rd_ptr_d  = rd_ptr_q + AW'(do_pop);
        level_d   = level_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        overrun_d = overrun_q;
        cnt_d     = cnt_q;
        // A drop in the same cycle as the clear wins and restarts the count at 1.
        if (drop) begin
            overrun_d = 1'b1;
            if (bus.trig_i2si_fifo_overrun_clr) cnt_d = 8'd1;
            else if (cnt_q != 8'hff)            cnt_d = cnt_q + 8'd1;
        end else if (bus.trig_i2si_fifo_overrun_clr) begin
            overrun_d = 1'b0;
            cnt_d     = 8'd0;
        end
    end

    // Pointer, level and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
            cnt_q     <= 8'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
        end
    end

    // Sample storage; contents are don't-care after reset since level gates them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= bus.i2si_din;
    end

    // Outputs come only from registers, so dout has no path from push/pop.
    assign bus.dout        = is_empty ? '0 : mem_q[rd_ptr_q];
    assign bus.empty       = is_empty;
    assign bus.full        = is_full;
    assign bus.level       = level_q;
    assign bus.overrun     = overrun_q;
    assign bus.overrun_cnt = cnt_q;
endmodule

// File: tb/tb_i2si_rx_fifo.sv
// Bench for i2si_rx_fifo: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_i2si_rx_fifo;
    localparam int DW = 16, DEPTH = 8, AW = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    i2si_rx_fifo_if #(.DW(DW), .AW(AW)) bif ();
    i2si_rx_fifo #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

    int tests = 0;
    int fails = 0;

    // Reference model: contents as a queue, status as plain values.
    logic [DW-1:0] q[$];
    bit            m_ovr;
    int            m_cnt;

    typedef struct {
        logic          push;
        logic [DW-1:0] din;
        logic          pop;
        logic          clr;
        int            lvl;
        logic [DW-1:0] dout;
        logic          ovr;
        int            cnt;
    } vec_t;
    vec_t vecs[26];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string name, input int lvl, input int dout, input int ovr, input int cnt);
        chk({name, " level"}, int'(bif.level), lvl);
        chk({name, " dout"}, int'(bif.dout), dout);
        chk({name, " empty"}, int'(bif.empty), int'(lvl == 0));
        chk({name, " full"}, int'(bif.full), int'(lvl == DEPTH));
        chk({name, " overrun"}, int'(bif.overrun), ovr);
        chk({name, " overrun_cnt"}, int'(bif.overrun_cnt), cnt);
    endtask

    task automatic chk_model(input string name);
        chk_state(name, q.size(), (q.size() != 0) ? int'(q[0]) : 0, int'(m_ovr), m_cnt);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovr = 1'b0;
        m_cnt = 0;
    endtask

    // Apply one cycle of stimulus, advance the model by the same rules, sample after the edge.
    task automatic cyc(input logic p, input logic [DW-1:0] d, input logic po, input logic c);
        bit dropped;
        bif.i2si_push = p;
        bif.i2si_din  = d;
        bif.pop       = po;
        bif.trig_i2si_fifo_overrun_clr = c;
        dropped = 1'b0;
        if (p && po && q.size() != 0) begin
            void'(q.pop_front());
            q.push_back(d);
        end else if (p) begin
            if (q.size() < DEPTH) q.push_back(d);
            else dropped = 1'b1;
        end else if (po && q.size() != 0) begin
            void'(q.pop_front());
        end
        if (dropped) begin
            m_ovr = 1'b1;
            m_cnt = c ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (c) begin
            m_ovr = 1'b0;
            m_cnt = 0;
        end
        @(posedge clk);
        #1;
        bif.i2si_push = 1'b0;
        bif.pop       = 1'b0;
        bif.trig_i2si_fifo_overrun_clr = 1'b0;
    endtask

    initial begin
        // Directed table: fill, overrun, clear, simultaneous events, drain.
        for (int i = 0; i < 8; i++) vecs[i] = '{1, DW'(i + 1), 0, 0, i + 1, 16'h0001, 0, 0};
        for (int i = 0; i < 3; i++) vecs[8 + i] = '{1, 16'h00a0 + DW'(i), 0, 0, 8, 16'h0001, 1, i + 1};
        vecs[11] = '{0, 16'h0000, 0, 1, 8, 16'h0001, 0, 0};
        vecs[12] = '{1, 16'h0099, 1, 0, 8, 16'h0002, 0, 0};
        vecs[13] = '{1, 16'h0055, 0, 1, 8, 16'h0002, 1, 1};
        for (int i = 0; i < 6; i++) vecs[14 + i] = '{0, 16'h0000, 1, 0, 7 - i, DW'(i + 3), 1, 1};
        vecs[20] = '{0, 16'h0000, 1, 0, 1, 16'h0099, 1, 1};
        vecs[21] = '{0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1};
        vecs[22] = '{0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1};
        vecs[23] = '{1, 16'h1234, 1, 0, 1, 16'h1234, 1, 1};
        vecs[24] = '{0, 16'h0000, 0, 1, 1, 16'h1234, 0, 0};
        vecs[25] = '{0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0};

        rst_n = 1'b0;
        bif.i2si_push = 1'b0;
        bif.i2si_din  = '0;
        bif.pop       = 1'b0;
        bif.trig_i2si_fifo_overrun_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            cyc(vecs[i].push, vecs[i].din, vecs[i].pop, vecs[i].clr);
            chk_state($sformatf("vec%0d", i), vecs[i].lvl, int'(vecs[i].dout), int'(vecs[i].ovr), vecs[i].cnt);
        end

        // Saturation: fill, then 300 dropped pushes.
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(16'h0200 + i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, DW'(16'hdead), 1'b0, 1'b0);
            chk_model("sat");
        end
        chk("sat final cnt", int'(bif.overrun_cnt), 255);
        chk("sat final ovr", int'(bif.overrun), 1);

        // Asynchronous reset mid-stream at level 5, away from any clock edge.
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        chk("pre-reset level", int'(bif.level), 5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_state("async reset", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, DW'(16'h0abc), 1'b0, 1'b0);
        chk_state("first push after reset", 1, 16'h0abc, 0, 0);

        // Interleaved push/pop across the pointer wrap.
        for (int i = 0; i < 5; i++) cyc(1'b1, DW'(16'h0300 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 2) cyc(1'b0, '0, 1'b1, 1'b0);
            else            cyc(1'b1, DW'(16'h0400 + i), 1'b1, 1'b0);
            chk_model("wrap");
        end

        // Random traffic with phases biased toward full and toward empty.
        for (int i = 0; i < 3000; i++) begin
            int pp, pq;
            pp = (i < 1000) ? 80 : ((i < 2000) ? 30 : 55);
            pq = (i < 1000) ? 30 : ((i < 2000) ? 80 : 55);
            cyc(($urandom_range(99) < pp), DW'($urandom), ($urandom_range(99) < pq), ($urandom_range(99) < 4));
            chk_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/i2si_rx_fifo.md
I2SI_RX_FIFO -- requirements
Module: i2si_rx_fifo

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning sample width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning FIFO entries, a power of two >= 2.
REQ-003 The block SHALL have parameter AW, default 3, meaning log2(DEPTH).
REQ-004 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  input  1  is the reset: asynchronous, active-low.
REQ-006 Port i2si_push  input  1  carries a one-cycle strobe; a sample is valid on i2si_din.
REQ-007 Port i2si_din  input  DW  carries the received I2S sample.
REQ-008 Port pop  input  1  carries the consumer read strobe; it removes the head entry.
REQ-009 Port trig_i2si_fifo_overrun_clr  input  1  carries a one-cycle pulse that clears the overrun status.
REQ-010 Port dout  output  DW  presents the head entry (show-ahead).
REQ-011 Port empty  output  1  is high when the FIFO holds 0 entries.
REQ-012 Port full  output  1  is high when the FIFO holds DEPTH entries.
REQ-013 Port level  output  AW+1  gives the number of stored entries, 0..DEPTH.
REQ-014 Port overrun  output  1  is a sticky flag, set when a sample is dropped.
REQ-015 Port overrun_cnt  output  8  counts dropped samples and saturates at 255.

Function
REQ-016 Storage SHALL be DEPTH x DW registers, with write and read pointers of AW bits that wrap modulo DEPTH.
REQ-017 level SHALL be a registered count; empty SHALL equal (level==0) and full SHALL equal (level==DEPTH).
REQ-018 A push with !full SHALL write i2si_din at wr_ptr and increment wr_ptr and level at the same edge.
REQ-019 A push with full and no pop SHALL drop the sample, leave storage, pointers and level unchanged, and set overrun.
REQ-020 A dropped push SHALL increment overrun_cnt by 1, saturating at 255 (no wrap).
REQ-021 A push and pop in the same cycle while full SHALL both be performed: the head is removed, the new sample is stored, level stays DEPTH, and no overrun occurs.
REQ-022 A pop with !empty SHALL increment rd_ptr and decrement level; a pop with empty SHALL be ignored, with no flag and no state change.
REQ-023 A push and pop in the same cycle while empty SHALL accept the push, ignore the pop, and produce level=1.
REQ-024 A push and pop in the same cycle when 0 < level < DEPTH SHALL perform both, leaving level unchanged.
REQ-025 dout SHALL equal mem[rd_ptr] when !empty and SHALL be 0 when empty, with no combinational path from push/pop inputs.
REQ-026 Latency: a sample pushed into an empty FIFO at edge N SHALL appear on dout, with empty low, after edge N.
REQ-027 trig_i2si_fifo_overrun_clr high at an edge SHALL clear overrun and overrun_cnt to 0.
REQ-028 When a dropped push and trig_i2si_fifo_overrun_clr occur in the same cycle, set SHALL win: overrun=1, overrun_cnt=1.
REQ-029 trig_i2si_fifo_overrun_clr SHALL NOT affect FIFO contents, pointers or level.
REQ-030 A clear pulse held for multiple cycles SHALL keep the status at 0, except for REQ-028 cycles.

Reset
REQ-031 On rst_n low the block SHALL immediately, without waiting for a clock edge, force:
- wr_ptr=0, rd_ptr=0, level=0
- empty=1, full=0, dout=0
- overrun=0, overrun_cnt=0
REQ-032 Storage contents need not be reset.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries.
REQ-034 The first push after rst_n deasserts SHALL be accepted normally.

Verification
REQ-035 Fill and drain: push 0x0001..0x0008 with no pop.
- Required: full=1 and level=8 after the 8th push.
- Then pop 8 times: dout reads 0x0001..0x0008 in order, then empty=1 and dout=0.
REQ-036 Overrun: with the FIFO full, push 3 more samples.
- Required: overrun=1, overrun_cnt=3, contents unchanged.
- Then pulse trig_i2si_fifo_overrun_clr: overrun=0, overrun_cnt=0, level still 8.
REQ-037 Simultaneous events:
- Full with push+pop: level=8, overrun=0, new sample at the tail.
- Empty with push+pop: level=1, dout=the pushed sample.
REQ-038 Set-vs-clear: a dropped push in the same cycle as the clear pulse gives overrun=1, overrun_cnt=1.
REQ-039 Saturation: 300 dropped pushes give overrun_cnt=255.
REQ-040 Pointer wrap and reset:
- Run 20 interleaved push/pop cycles across the wrap; data order SHALL be preserved.
- Assert rst_n low mid-stream with level=5: empty=1, level=0 and overrun=0 asynchronously.
